// File: rtl/image_pkg.sv
// Shared image-pipeline definitions.
// Holds the default pixel/line geometry, the pixel_t type and the
// line_buffer FSM state encoding (lb_state_e).
package image_pkg;

  localparam int IMG_DATA_WIDTH  = 8;
  localparam int IMG_IMAGE_WIDTH = 10;
  localparam int IMG_WIN_SIZE    = 3;

  typedef logic [IMG_DATA_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } lb_state_e;

endpackage

// File: rtl/line_mem.sv
// One image line of pixel storage.
// Ports:
//   clk   - clock
//   we    - write enable; wdata is stored at addr on the rising edge
//   addr  - shared read/write address
//   wdata - write data
//   rdata - asynchronous read of the entry at addr (pre-write value)
// Contents are not reset.
module line_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 10
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/line_buffer.sv
// Line buffer: keeps the last WIN_SIZE-1 image lines and, for every accepted
// pixel, emits that pixel plus the vertically aligned pixels of the previous
// lines, one cycle after acceptance.
//
// Handshake: pixel_valid is a pure strobe with no backpressure; every cycle
// with pixel_valid=1 consumes one pixel, and pixel_valid_out is pixel_valid
// delayed by one cycle. When pixel_valid=0 nothing changes and the data
// outputs hold.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   sof              - start of frame, qualified by pixel_valid
//   pixel_valid      - input strobe
//   pixel_in         - input pixel
//   pixel_valid_out  - output strobe
//   pixel_out        - registered copy of the accepted pixel
//   line_out[k]      - pixel from row r-1-k, same column
//   col_idx/row_idx  - position of the output pixel (row saturates)
//   lines_ready      - row_idx >= WIN_SIZE-1
//   eol              - output pixel is last of its line
//   state_dbg        - current FSM state (lb_state_e encoding)
//
// Build option: define LINE_BUFFER_ZERO_PAD_EN to force line_out[k] to 0
// while row_idx <= k (top border / lines not yet filled in this frame).
module line_buffer
  import image_pkg::*;
#(
  parameter int DATA_WIDTH  = IMG_DATA_WIDTH,
  parameter int IMAGE_WIDTH = IMG_IMAGE_WIDTH,
  parameter int WIN_SIZE    = IMG_WIN_SIZE,
  parameter int ROW_W       = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 sof,
  input  logic                                 pixel_valid,
  input  logic [DATA_WIDTH-1:0]                pixel_in,
  output logic                                 pixel_valid_out,
  output logic [DATA_WIDTH-1:0]                pixel_out,
  output logic [WIN_SIZE-2:0][DATA_WIDTH-1:0]  line_out,
  output logic [$clog2(IMAGE_WIDTH)-1:0]       col_idx,
  output logic [ROW_W-1:0]                     row_idx,
  output logic                                 lines_ready,
  output logic                                 eol,
  output logic [1:0]                           state_dbg
);

  localparam int NUM_LINES = WIN_SIZE - 1;
  localparam int COL_W     = $clog2(IMAGE_WIDTH);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] FULL_ROW = ROW_W'(WIN_SIZE - 1);

  // Write-side position and FSM
  lb_state_e        state_q,  state_d;
  logic [COL_W-1:0] wr_col_q, wr_col_d;
  logic [ROW_W-1:0] row_q,    row_d;

  // Output registers
  logic                                valid_out_q,   valid_out_d;
  logic [DATA_WIDTH-1:0]               pixel_out_q,   pixel_out_d;
  logic [NUM_LINES-1:0][DATA_WIDTH-1:0] line_out_q,   line_out_d;
  logic [COL_W-1:0]                    col_idx_q,     col_idx_d;
  logic [ROW_W-1:0]                    row_idx_q,     row_idx_d;
  logic                                lines_ready_q, lines_ready_d;
  logic                                eol_q,         eol_d;

  // sof relocates the current pixel to (0,0) before it is used anywhere,
  // including as the memory address.
  logic [COL_W-1:0] eff_col;
  logic [ROW_W-1:0] eff_row;
  logic             sof_acc;

  logic [DATA_WIDTH-1:0] rd_data [NUM_LINES];
  logic [DATA_WIDTH-1:0] wr_data [NUM_LINES];

  assign sof_acc = sof & pixel_valid;
  assign eff_col = sof_acc ? '0 : wr_col_q;
  assign eff_row = sof_acc ? '0 : row_q;

  // Cascade: line 0 takes the new pixel, line k takes line k-1's pre-write
  // value at the same column, so one write cycle shifts the column up.
  for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
    if (k == 0) begin : g_first
      assign wr_data[k] = pixel_in;
    end else begin : g_rest
      assign wr_data[k] = rd_data[k-1];
    end

    line_mem #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (IMAGE_WIDTH)
    ) u_mem (
      .clk  (clk),
      .we   (pixel_valid),
      .addr (eff_col),
      .wdata(wr_data[k]),
      .rdata(rd_data[k])
    );
  end

  always_comb begin
    state_d       = state_q;
    wr_col_d      = wr_col_q;
    row_d         = row_q;
    valid_out_d   = pixel_valid;
    pixel_out_d   = pixel_out_q;
    line_out_d    = line_out_q;
    col_idx_d     = col_idx_q;
    row_idx_d     = row_idx_q;
    lines_ready_d = lines_ready_q;
    eol_d         = eol_q;

    if (pixel_valid) begin
      pixel_out_d   = pixel_in;
      col_idx_d     = eff_col;
      row_idx_d     = eff_row;
      eol_d         = (eff_col == LAST_COL);
      lines_ready_d = (eff_row >= FULL_ROW);

      for (int k = 0; k < NUM_LINES; k++) begin
`ifdef LINE_BUFFER_ZERO_PAD_EN
        line_out_d[k] = (eff_row <= ROW_W'(k)) ? '0 : rd_data[k];
`else
        line_out_d[k] = rd_data[k];
`endif
      end

      if (eff_col == LAST_COL) begin
        wr_col_d = '0;
        row_d    = (eff_row == '1) ? eff_row : eff_row + ROW_W'(1);
      end else begin
        wr_col_d = eff_col + COL_W'(1);
        row_d    = eff_row;
      end

      // State mirrors the row that the next pixel will be written into.
      if (sof_acc) begin
        state_d = FILL;
      end else if (row_d >= FULL_ROW) begin
        state_d = STREAM;
      end else begin
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_col_q      <= '0;
      row_q         <= '0;
      valid_out_q   <= 1'b0;
      pixel_out_q   <= '0;
      line_out_q    <= '0;
      col_idx_q     <= '0;
      row_idx_q     <= '0;
      lines_ready_q <= 1'b0;
      eol_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_col_q      <= wr_col_d;
      row_q         <= row_d;
      valid_out_q   <= valid_out_d;
      pixel_out_q   <= pixel_out_d;
      line_out_q    <= line_out_d;
      col_idx_q     <= col_idx_d;
      row_idx_q     <= row_idx_d;
      lines_ready_q <= lines_ready_d;
      eol_q         <= eol_d;
    end
  end

  assign pixel_valid_out = valid_out_q;
  assign pixel_out       = pixel_out_q;
  assign line_out        = line_out_q;
  assign col_idx         = col_idx_q;
  assign row_idx         = row_idx_q;
  assign lines_ready     = lines_ready_q;
  assign eol             = eol_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_line_buffer.sv
// Testbench for line_buffer (default geometry: 8-bit pixels, 10 per line,
// 2 stored lines). Expected outputs come from a behavioural line model and
// are queued when a pixel is driven, then popped when pixel_valid_out shows.
module tb_line_buffer;
  import image_pkg::*;

  localparam int DW = 8;
  localparam int IW = 10;
  localparam int WS = 3;
  localparam int RW = 16;
  localparam int CW = $clog2(IW);
  localparam int NL = WS - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   sof;
  logic                   pixel_valid;
  pixel_t                 pixel_in;
  logic                   pixel_valid_out;
  logic [DW-1:0]          pixel_out;
  logic [NL-1:0][DW-1:0]  line_out;
  logic [CW-1:0]          col_idx;
  logic [RW-1:0]          row_idx;
  logic                   lines_ready;
  logic                   eol;
  logic [1:0]             state_dbg;

  line_buffer #(
    .DATA_WIDTH (DW),
    .IMAGE_WIDTH(IW),
    .WIN_SIZE   (WS),
    .ROW_W      (RW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sof            (sof),
    .pixel_valid    (pixel_valid),
    .pixel_in       (pixel_in),
    .pixel_valid_out(pixel_valid_out),
    .pixel_out      (pixel_out),
    .line_out       (line_out),
    .col_idx        (col_idx),
    .row_idx        (row_idx),
    .lines_ready    (lines_ready),
    .eol            (eol),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [DW-1:0]         pix;
    logic [NL-1:0][DW-1:0] line;
    logic [NL-1:0]         line_chk;  // entry holds known data
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  eol;
    logic                  rdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;

  logic [DW-1:0] m_mem [NL][IW];
  logic          m_vld [NL][IW];
  int            m_col;
  int            m_row;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_out(input exp_t e);
    chk("pixel_out", 64'(pixel_out), 64'(e.pix));
    chk("col_idx", 64'(col_idx), 64'(e.col));
    chk("row_idx", 64'(row_idx), 64'(e.row));
    chk("eol", 64'(eol), 64'(e.eol));
    chk("lines_ready", 64'(lines_ready), 64'(e.rdy));
    for (int k = 0; k < NL; k++) begin
      if (e.line_chk[k]) chk($sformatf("line_out[%0d]", k), 64'(line_out[k]), 64'(e.line[k]));
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic s, input logic [DW-1:0] p);
    exp_t e;
    @(negedge clk);
    pixel_valid = v;
    sof         = s;
    pixel_in    = p;
    if (v) begin
      if (s) begin
        m_col = 0;
        m_row = 0;
      end
      e.pix = p;
      for (int k = 0; k < NL; k++) begin
        e.line[k]     = m_mem[k][m_col];
        e.line_chk[k] = m_vld[k][m_col];
`ifdef LINE_BUFFER_ZERO_PAD_EN
        if (m_row <= k) begin
          e.line[k]     = '0;
          e.line_chk[k] = 1'b1;
        end
`endif
      end
      e.col = CW'(m_col);
      e.row = RW'(m_row);
      e.eol = (m_col == IW - 1);
      e.rdy = (m_row >= WS - 1);
      for (int k = NL - 1; k > 0; k--) begin
        m_mem[k][m_col] = m_mem[k-1][m_col];
        m_vld[k][m_col] = m_vld[k-1][m_col];
      end
      m_mem[0][m_col] = p;
      m_vld[0][m_col] = 1'b1;
      if (m_col == IW - 1) begin
        m_col = 0;
        m_row = m_row + 1;
      end else begin
        m_col = m_col + 1;
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("pixel_valid_out", 64'(pixel_valid_out), 64'(v));
    if (pixel_valid_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(exp_q.size()), 64'd1);
      end else begin
        last_e = exp_q.pop_front();
        compare_out(last_e);
      end
    end else begin
      // Stall: everything must hold the previous output.
      compare_out(last_e);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst         = 1'b1;
    pixel_valid = 1'b0;
    sof         = 1'b0;
    pixel_in    = 8'd0;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_valid_out", 64'(pixel_valid_out), 64'd0);
    chk("rst_pixel_out", 64'(pixel_out), 64'd0);
    chk("rst_line_out", 64'(line_out), 64'd0);
    chk("rst_col_idx", 64'(col_idx), 64'd0);
    chk("rst_row_idx", 64'(row_idx), 64'd0);
    chk("rst_lines_ready", 64'(lines_ready), 64'd0);
    chk("rst_eol", 64'(eol), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'(IDLE));
    @(negedge clk);
    rst   = 1'b0;
    m_col = 0;
    m_row = 0;
    exp_q.delete();
    last_e          = '0;
    last_e.line_chk = '1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b0;
    sof         = 1'b0;
    pixel_valid = 1'b0;
    pixel_in    = '0;
    for (int k = 0; k < NL; k++)
      for (int c = 0; c < IW; c++) begin
        m_mem[k][c] = '0;
        m_vld[k][c] = 1'b0;
      end

    do_reset(2);

    // Frame 1: rows 0..4, pixel = r*10+c; stall toggling early in row 2.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < IW; c++) begin
        drive(1'b1, (r == 0 && c == 0), 8'(r * 10 + c));
        if (r == 1 && c == 9) chk("ready_low_r1c9", 64'(lines_ready), 64'd0);
        if (r == 2 && c == 0) chk("ready_rise_r2c0", 64'(lines_ready), 64'd1);
        if (r == 2 && c == 5) chk("align_r2c5_line0", 64'(line_out[0]), 64'd15);
        if (r == 3 && c == 4) begin
          chk("r3c4_pixel", 64'(pixel_out), 64'd34);
          chk("r3c4_line0", 64'(line_out[0]), 64'd24);
          chk("r3c4_line1", 64'(line_out[1]), 64'd14);
          chk("r3c4_ready", 64'(lines_ready), 64'd1);
          chk("r3c4_state", 64'(state_dbg), 64'(STREAM));
        end
        if (c == 9) begin
          chk("eol_at_col9", 64'(eol), 64'd1);
          chk("col9_idx", 64'(col_idx), 64'd9);
        end
        if (r == 2 && c < 4) drive(1'b0, 1'b0, 8'hEE);   // stall bubble
        if (r == 4 && c == 3) drive(1'b0, 1'b1, 8'd99);  // lone sof ignored
      end
    end

    // Frame 2: sof reasserted at row 3 col 6 with value 200.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (r == 3 && c == 6) break;
        drive(1'b1, (r == 0 && c == 0), 8'(r * 10 + c + 100));
      end
    end
    drive(1'b1, 1'b1, 8'd200);
    chk("sof_pixel", 64'(pixel_out), 64'd200);
    chk("sof_col", 64'(col_idx), 64'd0);
    chk("sof_row", 64'(row_idx), 64'd0);
    chk("sof_ready", 64'(lines_ready), 64'd0);
    chk("sof_state", 64'(state_dbg), 64'(FILL));
`ifdef LINE_BUFFER_ZERO_PAD_EN
    chk("sof_line_zero", 64'(line_out), 64'd0);
`endif
    for (int i = 0; i < 14; i++) drive(1'b1, 1'b0, 8'($urandom_range(0, 255)));

    // Frame 3: reset mid row 2.
    for (int i = 0; i < 2 * IW + 3; i++) drive(1'b1, (i == 0), 8'($urandom_range(0, 255)));
    do_reset(1);
    drive(1'b1, 1'b0, 8'd77);
    chk("post_rst_col", 64'(col_idx), 64'd0);
    chk("post_rst_row", 64'(row_idx), 64'd0);
    chk("post_rst_pixel", 64'(pixel_out), 64'd77);

    // Random valid pattern across several lines.
    for (int i = 0; i < 60; i++)
      drive(1'($urandom_range(0, 3) != 0), 1'b0, 8'($urandom_range(0, 255)));

    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_buffer.md
# line_buffer

Stores the most recent WIN_SIZE-1 image lines of a raster pixel stream. For every accepted pixel it emits that pixel together with the vertically aligned pixels from the previous lines. It is the producer for the sliding-window stage: `pixel_out` drives the window stage's `pixel_in`, `line_out` drives its `line_out`, and `pixel_valid_out` drives its `pixel_valid`. It sits between the camera/pixel ingress and the window/convolution pipeline.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width in bits
- IMAGE_WIDTH, 10, pixels per line (≥2)
- WIN_SIZE, 3, window height; WIN_SIZE-1 lines are stored (≥2)
- ROW_W, 16, width of the row counter

Ports:
- clk  in  1  clock. One clock domain; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high
- sof  in  1  start of frame; qualified by pixel_valid; marks the pixel as row 0, col 0
- pixel_valid  in  1  input pixel strobe
- pixel_in  in  DATA_WIDTH  input pixel
- pixel_valid_out  out  1  output strobe
- pixel_out  out  DATA_WIDTH  delayed copy of pixel_in
- line_out  out  DATA_WIDTH x [WIN_SIZE-2:0]  line_out[k] is the pixel from row r-1-k, same column
- col_idx  out  $clog2(IMAGE_WIDTH)  column of the current output pixel
- row_idx  out  ROW_W  row of the current output pixel; saturates at all-ones
- lines_ready  out  1  high once row_idx ≥ WIN_SIZE-1, so all line_out entries hold real data
- eol  out  1  output pixel is the last pixel of its line

## Operation
- Storage: WIN_SIZE-1 line memories, each IMAGE_WIDTH deep, all addressed by the shared write pointer `wr_col`.
- On an accepted pixel (pixel_valid=1), in the same cycle:
  - mem[0][wr_col] ← pixel_in
  - mem[k][wr_col] ← mem[k-1][wr_col] for k ≥ 1, using pre-write read values, so the cascade behaves as a shift
  - the pre-write read values are registered into line_out
- `wr_col` increments on each accepted pixel and wraps from IMAGE_WIDTH-1 to 0. On the wrap, the row counter increments and saturates.
- FSM states:
  - IDLE: after reset; waits for pixel_valid.
  - FILL: row < WIN_SIZE-1.
  - STREAM: row ≥ WIN_SIZE-1.
- FSM transitions:
  - IDLE→FILL on the first accepted pixel.
  - FILL→STREAM on the wrap that completes row WIN_SIZE-2.
  - Any state→FILL on sof&pixel_valid.
- sof&pixel_valid forces the pixel to col 0 / row 0, with the counters cleared before the pixel is used. Memory is not cleared.
- sof asserted without pixel_valid is ignored.
- pixel_valid=0 is a stall: no state changes, and pixel_valid_out=0 next cycle. The data outputs hold their values.
- No backpressure; the block always accepts input.

## Timing
- Latency is 1 cycle: pixel_out, line_out, col_idx, row_idx, eol and lines_ready all update on the edge after acceptance, mutually aligned. pixel_valid_out is the 1-cycle-delayed pixel_valid.
- Back-to-back pixels stream with no bubbles.
- Reset values: pixel_valid_out=0, pixel_out=0, line_out all 0, col_idx=0, row_idx=0, lines_ready=0, eol=0, FSM=IDLE, wr_col=0. Memory contents are not reset.
- Reset mid-line discards the partial line. The next pixel is treated as row 0, col 0.
- Wrap: eol=1 exactly when col_idx=IMAGE_WIDTH-1.

## Configuration
- Macro `LINE_BUFFER_ZERO_PAD_EN`:
  - Defined: line_out[k] is forced to 0 while row_idx ≤ k, covering the top border and lines not yet filled after sof or reset.
  - Undefined: line_out carries the raw memory contents. These are undefined until filled, and stale across a frame boundary after sof.

## Structure
- Shared package `image_pkg` holds:
  - default DATA_WIDTH, IMAGE_WIDTH and WIN_SIZE constants
  - `pixel_t` typedef
  - the FSM state enum `lb_state_e` (IDLE, FILL, STREAM)
- One sub-module, `line_mem`: a single line of storage with parameters DATA_WIDTH and DEPTH, one write port and an asynchronous read at the same address. It is instantiated WIN_SIZE-1 times.

## Test plan
1. Reset, then stream 5 rows × 10 pixels with pixel_in=r*10+c and sof on the first pixel.
   - Row 3, col 4 output: pixel_out=34, line_out[0]=24, line_out[1]=14, lines_ready=1.
2. ZERO_PAD_EN defined, same stream.
   - Row 0: line_out={0,0}.
   - Row 1, col 2: line_out[0]=2, line_out[1]=0.
   - lines_ready rises at the row 2, col 0 output.
3. Stall pattern: pixel_valid toggles 1,0,1,0 during row 2.
   - pixel_valid_out mirrors it delayed by 1 cycle.
   - Outputs hold during gaps.
   - Column alignment is still correct (row 2, col 5: line_out[0]=15).
4. eol check.
   - eol=1 only with col_idx=9.
   - row_idx increments on the next output pixel.
5. sof reasserted at row 3, col 6 with value 200.
   - Output: pixel_out=200, col_idx=0, row_idx=0, lines_ready=0.
   - With ZERO_PAD_EN, line_out is all 0.
6. rst pulsed mid-row 2 for 1 cycle.
   - All outputs are 0 the next cycle.
   - The following pixel reports col_idx=0, row_idx=0.
